// File: rtl/cla_seq_adder.sv
// Nibble-serial add/subtract: one 4-bit carry-lookahead slice reused LSB->MSB.
// Result and flags are registered and held until the next accepted start.

module CarryLookAheadAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [3:0] g, p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[3:0];
    c_out = c[4];
  end
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [BW-1:0]    base;
  logic [3:0]       sl_a, sl_b, sl_sum;
  logic             sl_cout;
  logic [WIDTH-1:0] result_nxt;

  always_comb begin
    base       = BW'({idx, 2'b00});
    sl_a       = a_reg[base +: 4];
    sl_b       = b_reg[base +: 4];
    result_nxt = result;
    result_nxt[base +: 4] = sl_sum;
  end

  CarryLookAheadAdder u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (carry_reg),
    .sum   (sl_sum),
    .c_out (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1; the +1 enters as the first slice carry.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result    <= result_nxt;
          carry_reg <= sl_cout;
          if (idx == LAST) begin
            state    <= DONE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            c_out    <= sl_cout;
            // Carry into the MSB recovered from its sum bit.
            overflow <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sl_sum[3]) ^ sl_cout;
            zero     <= (result_nxt == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed vectors on WIDTH=16 plus a random sweep of WIDTH=4 and WIDTH=64 instances.
module tb_cla_seq_adder;
  logic        clk = 1'b0;
  logic        rst_n, sub;
  logic [63:0] a_in, b_in;
  logic        start4, start16, start64;

  logic        busy4, done4, c4, ov4, z4;
  logic [3:0]  res4;
  logic        busy16, done16, c16, ov16, z16;
  logic [15:0] res16;
  logic        busy64, done64, c64, ov64, z64;
  logic [63:0] res64;

  int          sel_w;
  logic        busy_s, done_s, c_s, ov_s, z_s;
  logic [63:0] res_s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub), .a(a_in[3:0]), .b(b_in[3:0]),
    .busy(busy4), .done(done4), .result(res4), .c_out(c4), .overflow(ov4), .zero(z4));
  cla_seq_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .a(a_in[15:0]), .b(b_in[15:0]),
    .busy(busy16), .done(done16), .result(res16), .c_out(c16), .overflow(ov16), .zero(z16));
  cla_seq_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .sub(sub), .a(a_in), .b(b_in),
    .busy(busy64), .done(done64), .result(res64), .c_out(c64), .overflow(ov64), .zero(z64));

  always_comb begin
    busy_s = busy16; done_s = done16; c_s = c16; ov_s = ov16; z_s = z16;
    res_s  = 64'(res16);
    case (sel_w)
      4: begin
        busy_s = busy4; done_s = done4; c_s = c4; ov_s = ov4; z_s = z4;
        res_s  = 64'(res4);
      end
      64: begin
        busy_s = busy64; done_s = done64; c_s = c64; ov_s = ov64; z_s = z64;
        res_s  = res64;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      4:       start4  = v;
      64:      start64 = v;
      default: start16 = v;
    endcase
  endtask

  // Independent wide-arithmetic reference for the random sweep.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] r, output logic c, output logic ov, output logic z);
    logic [64:0] mask, bb, sum;
    mask = (65'd1 << w) - 65'd1;
    bb   = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
    sum  = ({1'b0, a} & mask) + bb + 65'(s);
    c    = sum[w];
    r    = sum[63:0] & mask[63:0];
    ov   = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    z    = (r == 64'd0);
  endtask

  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] er, input logic ec, input logic eov, input logic ez,
                        input string tag);
    int n, lat;
    logic busy_ok;
    n = w / 4;
    sel_w = w;
    a_in = a; b_in = b; sub = s;
    set_start(w, 1'b1);
    cyc();
    set_start(w, 1'b0);
    // Scramble inputs: the block must use its captured copies.
    a_in = ~a; b_in = ~b; sub = ~s;
    lat = 1;
    busy_ok = 1'b1;
    while (!done_s && lat <= n + 4) begin
      if (!busy_s) busy_ok = 1'b0;
      cyc();
      lat++;
    end
    chk($sformatf("%s latency", tag), 64'(lat), 64'(n + 1));
    chk($sformatf("%s busy_run", tag), 64'(busy_ok), 64'd1);
    chk($sformatf("%s busy_done", tag), 64'(busy_s), 64'd0);
    chk($sformatf("%s result", tag), res_s, er);
    chk($sformatf("%s c_out", tag), 64'(c_s), 64'(ec));
    chk($sformatf("%s overflow", tag), 64'(ov_s), 64'(eov));
    chk($sformatf("%s zero", tag), 64'(z_s), 64'(ez));
    cyc();
    chk($sformatf("%s done_pulse", tag), 64'(done_s), 64'd0);
    chk($sformatf("%s result_hold", tag), res_s, er);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb, er, mask;
    logic        rs, ec, eov, ez, seen_done;
    int          w;

    rst_n = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
    start4 = 1'b0; start16 = 1'b0; start64 = 1'b0; sel_w = 16;
    #12;
    chk("reset busy", 64'(busy16), 64'd0);
    chk("reset done", 64'(done16), 64'd0);
    chk("reset result", 64'(res16), 64'd0);
    chk("reset flags", 64'({c16, ov16, z16}), 64'd0);
    chk("reset w64", 64'({busy64, done64, c64, ov64, z64}) | res64, 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    run_op(16, 64'h1234, 64'h4321, 1'b0, 64'h5555, 1'b0, 1'b0, 1'b0, "add");
    run_op(16, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1, "carry_zero");
    run_op(16, 64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1, 1'b0, "ovf_add");
    run_op(16, 64'h8000, 64'h0001, 1'b1, 64'h7FFF, 1'b1, 1'b1, 1'b0, "ovf_sub");
    run_op(16, 64'h0003, 64'h0005, 1'b1, 64'hFFFE, 1'b0, 1'b0, 1'b0, "neg_sub");

    // Handshake: start in cycle 2 ignored, back-to-back start in the DONE cycle.
    sel_w = 16;
    a_in = 64'h1111; b_in = 64'h2222; sub = 1'b0; start16 = 1'b1;
    cyc();                                   // cycle 1
    start16 = 1'b0;
    cyc();                                   // cycle 2
    a_in = 64'hAAAA; b_in = 64'h0F0F; sub = 1'b1; start16 = 1'b1;
    cyc();                                   // cycle 3
    start16 = 1'b0;
    chk("hs busy_c3", 64'(busy16), 64'd1);
    cyc();                                   // cycle 4
    chk("hs done_c4", 64'(done16), 64'd0);
    cyc();                                   // cycle 5
    chk("hs done_c5", 64'(done16), 64'd1);
    chk("hs busy_c5", 64'(busy16), 64'd0);
    chk("hs result1", 64'(res16), 64'h3333);
    a_in = 64'h1; b_in = 64'h1; sub = 1'b0; start16 = 1'b1;
    cyc();                                   // cycle 6
    start16 = 1'b0;
    chk("hs done_c6", 64'(done16), 64'd0);
    chk("hs busy_c6", 64'(busy16), 64'd1);
    for (int i = 7; i <= 9; i++) begin
      cyc();
      chk($sformatf("hs busy_c%0d", i), 64'({busy16, done16}), 64'b10);
    end
    cyc();                                   // cycle 10
    chk("hs done_c10", 64'(done16), 64'd1);
    chk("hs result2", 64'(res16), 64'h0002);

    // Reset mid-op: flags from a prior carry/zero result must be cleared.
    run_op(16, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1, "pre_rst");
    a_in = 64'h0F0F; b_in = 64'h1010; sub = 1'b0; start16 = 1'b1;
    cyc();
    start16 = 1'b0;
    cyc();
    cyc();                                   // cycle 3
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", 64'(busy16), 64'd0);
    chk("rst result", 64'(res16), 64'd0);
    chk("rst flags", 64'({done16, c16, ov16, z16}), 64'd0);
    cyc();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (done16 || busy16) seen_done = 1'b1;
    end
    chk("rst no_done", 64'(seen_done), 64'd0);
    run_op(16, 64'h00FF, 64'h0001, 1'b0, 64'h0100, 1'b0, 1'b0, 1'b0, "post_rst");

    // Random sweep of the narrow and wide instances.
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 4 : 64;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom} & mask;
        rb = {$urandom, $urandom} & mask;
        rs = 1'($urandom_range(0, 1));
        model(w, ra, rb, rs, er, ec, eov, ez);
        run_op(w, ra, rb, rs, er, ec, eov, ez, $sformatf("w%0d_%0d", w, i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
